csr_mstatus_trap: RTL and testbench
===================================

# csr_mstatus_trap

Parametrised machine-status CSR for the core's CSR file. It adds optional U-mode support (MPP, MPRV, TW), XLEN 32/64 layout, full write/set/clear access, and hardware trap-entry/MRET sequencing. It also owns the current-privilege register. Reads are registered: ack and read data appear one cycle after the access and return the pre-update value.

## Interface
- XLEN, 32: register width; legal values 32 or 64.
- ADDRESS, 12'h300: CSR address decoded.
- HAS_UMODE, 0: 1 enables U-mode, writable MPP/MPRV/TW, and UXL (XLEN=64 only).
- MPP_RESET, 2'b11: MPP value at reset; must be a legal MPP.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- en_i  in  1  CSR access strobe, one cycle.
- addr_i  in  12  CSR address.
- op_i  in  2  00 read only, 01 write, 10 set, 11 clear.
- wdata_i  in  XLEN  write value or set/clear mask.
- trap_i  in  1  trap-entry pulse from the commit stage.
- mret_i  in  1  MRET-commit pulse.
- ack_o  out  1  registered acknowledge, one cycle after a matching access.
- rdata_o  out  XLEN  registered read data, valid while ack_o=1, 0 otherwise.
- value_o  out  XLEN  live mstatus value, combinational from state.
- priv_o  out  2  current privilege: 11 = M, 00 = U.
- irq_en_o  out  1  global interrupt enable = MIE | (priv_o != 11).

## Operation
- Storage: MIE[3], MPIE[7], MPP[12:11], MPRV[17], TW[21], and a 2-bit privilege register.
- Read-only fields:
  - SD[XLEN-1] = 0; XS[16:15] = 0; FS[14:13] = 0.
  - With XLEN=64 and HAS_UMODE=1, UXL[33:32] = 2'b10; otherwise those bits read 0.
  - All other bits read 0.
- HAS_UMODE=0: MPP reads 11 constant; MPRV and TW read 0; writes to them are ignored. priv_o is always 11.
- Access match: en_i && addr_i == ADDRESS.
- On a matching access with op_i != 00, the new value is computed from the current field values:
  - write: new = wdata_i
  - set: new = old | wdata_i
  - clear: new = old & ~wdata_i
  - Only writable bits are updated.
- MPP is WARL. Legal values are 11, and 00 when HAS_UMODE=1. An illegal new MPP leaves MPP unchanged; other fields in the same write still update.
- Trap entry (trap_i): MPIE <= MIE, MIE <= 0, MPP <= priv, priv <= 11.
- MRET (mret_i): MIE <= MPIE, MPIE <= 1, priv <= MPP, MPP <= 00 if HAS_UMODE else 11. MPRV <= 0 when the new priv is not 11.
- Priority when events coincide in one cycle: trap_i > mret_i > CSR write.
  - The lower-priority update is discarded entirely.
  - A discarded CSR write is still acknowledged, with rdata_o = the value before that edge.

## Timing
- Reset values (rst_i low, asynchronous):
  - MIE = 0, MPIE = 0, MPP = MPP_RESET, MPRV = 0, TW = 0, priv = 11.
  - ack_o = 0, rdata_o = 0.
- Read/ack latency:
  - Matching access in cycle N gives ack_o = 1 and rdata_o = value_o as sampled in cycle N (read-old) in cycle N+1.
  - The field update takes effect at the same edge, so value_o shows it from cycle N+1.
- Back-to-back accesses on every cycle are supported: each is acknowledged exactly one cycle later with no bubble.
- Non-matching access: no ack, no state change.
- trap_i/mret_i effects are visible on value_o, priv_o and irq_en_o the cycle after the pulse.
- Reset asserted in mid-access suppresses the pending ack; ack_o is 0 in the first cycle after release.

## Test plan
- Reset release -> value_o = 32'h0000_1800 (HAS_UMODE=0), priv_o = 11, irq_en_o = 0, ack_o = 0.
- Write 32'hFFFF_FFFF at 12'h300 (XLEN=32, HAS_UMODE=1) -> next cycle ack_o = 1 and rdata_o = prior value; value_o = 32'h0022_1888.
- Set 32'h8, then trap_i -> after the trap, MIE = 0, MPIE = 1, MPP = 11, irq_en_o = 0. Then mret_i -> MIE = 1, MPIE = 1, MPP = 00 (HAS_UMODE=1), priv_o = 11.
- HAS_UMODE=1: write MPP = 00 then mret_i -> priv_o = 00, irq_en_o = 1, MPRV = 0. Write MPP = 01 -> MPP unchanged.
- trap_i, mret_i and a write of 32'h8 all in the same cycle -> trap semantics only, MIE = 0; ack_o = 1 next cycle with the pre-trap rdata_o.
- Access at 12'h301 -> no ack, value_o unchanged. Assert rst_i low in the cycle after an access -> ack_o drops immediately and all fields return to reset values.

Source files
------------

// File: rtl/csr_mstatus_trap.sv
// Machine-status CSR with optional U-mode, trap-entry/MRET sequencing and
// ownership of the current-privilege register. Reads are registered (read-old).
module csr_mstatus_trap #(
    parameter int          XLEN      = 32,
    parameter logic [11:0] ADDRESS   = 12'h300,
    parameter int          HAS_UMODE = 0,
    parameter logic [1:0]  MPP_RESET = 2'b11
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [11:0]     addr_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            trap_i,
    input  logic            mret_i,
    output logic            ack_o,
    output logic [XLEN-1:0] rdata_o,
    output logic [XLEN-1:0] value_o,
    output logic [1:0]      priv_o,
    output logic            irq_en_o
);

    localparam logic UMODE = (HAS_UMODE != 0);
    localparam logic [XLEN-1:0] UXL_BITS =
        (XLEN == 64 && HAS_UMODE != 0) ? XLEN'(64'h0000_0002_0000_0000) : '0;

    logic            r_mie;
    logic            r_mpie;
    logic [1:0]      r_mpp;
    logic            r_mprv;
    logic            r_tw;
    logic [1:0]      r_priv;
    logic            r_ack;
    logic [XLEN-1:0] r_rdata;

    logic [XLEN-1:0] w_value;
    logic [XLEN-1:0] w_new;
    logic            w_match;
    logic            w_write;
    logic            w_mpp_legal;
    logic            w_unused;

    // Without U-mode MPP is hard-wired to M; the stored copy is never observed.
    always_comb begin
        w_value      = UXL_BITS;
        w_value[3]   = r_mie;
        w_value[7]   = r_mpie;
        w_value[12:11] = UMODE ? r_mpp : 2'b11;
        w_value[17]  = r_mprv;
        w_value[21]  = r_tw;
    end

    always_comb begin
        case (op_i)
            2'b01:   w_new = wdata_i;
            2'b10:   w_new = w_value | wdata_i;
            2'b11:   w_new = w_value & ~wdata_i;
            default: w_new = w_value;
        endcase
    end

    assign w_match     = en_i && (addr_i == ADDRESS);
    assign w_write     = w_match && (op_i != 2'b00);
    assign w_mpp_legal = (w_new[12:11] == 2'b11) || (UMODE && (w_new[12:11] == 2'b00));
    assign w_unused    = ^{w_new, r_mpp};

    // Trap beats MRET beats a CSR write; the loser is dropped as a whole.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mie  <= 1'b0;
            r_mpie <= 1'b0;
            r_mpp  <= MPP_RESET;
            r_mprv <= 1'b0;
            r_tw   <= 1'b0;
            r_priv <= 2'b11;
        end else if (trap_i) begin
            r_mpie <= r_mie;
            r_mie  <= 1'b0;
            r_mpp  <= UMODE ? r_priv : 2'b11;
            r_priv <= 2'b11;
        end else if (mret_i) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
            r_priv <= UMODE ? r_mpp : 2'b11;
            r_mpp  <= UMODE ? 2'b00 : 2'b11;
            if (UMODE && (r_mpp != 2'b11)) begin
                r_mprv <= 1'b0;
            end
        end else if (w_write) begin
            r_mie  <= w_new[3];
            r_mpie <= w_new[7];
            if (w_mpp_legal) begin
                r_mpp <= w_new[12:11];
            end
            if (UMODE) begin
                r_mprv <= w_new[17];
                r_tw   <= w_new[21];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_match;
            r_rdata <= w_match ? w_value : '0;
        end
    end

    assign ack_o    = r_ack;
    assign rdata_o  = r_rdata;
    assign value_o  = w_value;
    assign priv_o   = r_priv;
    assign irq_en_o = r_mie | (r_priv != 2'b11);

endmodule

// File: tb/tb_csr_mstatus_trap.sv
// Directed bench for csr_mstatus_trap: three configurations (M-only 32-bit,
// U-mode 32-bit, U-mode 64-bit) share one stimulus stream.
module tb_csr_mstatus_trap;

    logic        clock;
    logic        resetN;
    logic        en;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [63:0] wdata;
    logic        trap;
    logic        mret;

    logic        ack0, ack1, ack64;
    logic [31:0] rdata0, rdata1, value0, value1;
    logic [63:0] rdata64, value64;
    logic [1:0]  priv0, priv1, priv64;
    logic        irq0, irq1, irq64;

    int errors = 0;
    int checks = 0;

    csr_mstatus_trap #(.XLEN(32), .ADDRESS(12'h300), .HAS_UMODE(0), .MPP_RESET(2'b11)) dut0 (
        .clk_i(clock), .rst_i(resetN), .en_i(en), .addr_i(addr), .op_i(op),
        .wdata_i(wdata[31:0]), .trap_i(trap), .mret_i(mret), .ack_o(ack0),
        .rdata_o(rdata0), .value_o(value0), .priv_o(priv0), .irq_en_o(irq0));

    csr_mstatus_trap #(.XLEN(32), .ADDRESS(12'h300), .HAS_UMODE(1), .MPP_RESET(2'b11)) dut1 (
        .clk_i(clock), .rst_i(resetN), .en_i(en), .addr_i(addr), .op_i(op),
        .wdata_i(wdata[31:0]), .trap_i(trap), .mret_i(mret), .ack_o(ack1),
        .rdata_o(rdata1), .value_o(value1), .priv_o(priv1), .irq_en_o(irq1));

    csr_mstatus_trap #(.XLEN(64), .ADDRESS(12'h300), .HAS_UMODE(1), .MPP_RESET(2'b11)) dut64 (
        .clk_i(clock), .rst_i(resetN), .en_i(en), .addr_i(addr), .op_i(op),
        .wdata_i(wdata), .trap_i(trap), .mret_i(mret), .ack_o(ack64),
        .rdata_o(rdata64), .value_o(value64), .priv_o(priv64), .irq_en_o(irq64));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic driveIdle();
        en    = 1'b0;
        addr  = 12'h300;
        op    = 2'b00;
        wdata = '0;
        trap  = 1'b0;
        mret  = 1'b0;
    endtask

    task automatic doReset();
        driveIdle();
        resetN = 1'b0;
        @(posedge clock);
        #1;
        resetN = 1'b1;
    endtask

    // Inputs are applied just after a rising edge and held for one cycle.
    task automatic stepAccess(input logic [11:0] a, input logic [1:0] o, input logic [63:0] d);
        en    = 1'b1;
        addr  = a;
        op    = o;
        wdata = d;
        @(posedge clock);
        #1;
        driveIdle();
    endtask

    task automatic stepEvent(input logic t, input logic m);
        trap = t;
        mret = m;
        @(posedge clock);
        #1;
        driveIdle();
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (value0 !== 32'h0000_1800) begin errors++; $display("[TB] FAIL reset_value0 got=%h exp=%h", value0, 32'h0000_1800); end
        checks++; if (priv0 !== 2'b11) begin errors++; $display("[TB] FAIL reset_priv0 got=%b exp=11", priv0); end
        checks++; if (irq0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq0 got=%b exp=0", irq0); end
        checks++; if (ack0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack0 got=%b exp=0", ack0); end
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata1 got=%h exp=0", rdata1); end
        checks++; if (value1 !== 32'h0000_1800) begin errors++; $display("[TB] FAIL reset_value1 got=%h exp=%h", value1, 32'h0000_1800); end
        checks++; if (value64 !== 64'h0000_0002_0000_1800) begin errors++; $display("[TB] FAIL reset_value64 got=%h exp=%h", value64, 64'h0000_0002_0000_1800); end
    endtask

    task automatic test_write();
        doReset();
        stepAccess(12'h300, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (ack1 !== 1'b1) begin errors++; $display("[TB] FAIL write_ack1 got=%b exp=1", ack1); end
        checks++; if (rdata1 !== 32'h0000_1800) begin errors++; $display("[TB] FAIL write_rdata1 got=%h exp=%h", rdata1, 32'h0000_1800); end
        checks++; if (value1 !== 32'h0022_1888) begin errors++; $display("[TB] FAIL write_value1 got=%h exp=%h", value1, 32'h0022_1888); end
        checks++; if (value0 !== 32'h0000_1888) begin errors++; $display("[TB] FAIL write_value0 got=%h exp=%h", value0, 32'h0000_1888); end
        checks++; if (value64 !== 64'h0000_0002_0022_1888) begin errors++; $display("[TB] FAIL write_value64 got=%h exp=%h", value64, 64'h0000_0002_0022_1888); end
        checks++; if (rdata64 !== 64'h0000_0002_0000_1800) begin errors++; $display("[TB] FAIL write_rdata64 got=%h exp=%h", rdata64, 64'h0000_0002_0000_1800); end
        @(posedge clock);
        #1;
        checks++; if (ack1 !== 1'b0) begin errors++; $display("[TB] FAIL write_idle_ack1 got=%b exp=0", ack1); end
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("[TB] FAIL write_idle_rdata1 got=%h exp=0", rdata1); end
    endtask

    task automatic test_trap_mret();
        doReset();
        stepAccess(12'h300, 2'b10, 64'h8);
        checks++; if (value1 !== 32'h0000_1808) begin errors++; $display("[TB] FAIL set_value1 got=%h exp=%h", value1, 32'h0000_1808); end
        checks++; if (irq1 !== 1'b1) begin errors++; $display("[TB] FAIL set_irq1 got=%b exp=1", irq1); end
        stepEvent(1'b1, 1'b0);
        checks++; if (value1 !== 32'h0000_1880) begin errors++; $display("[TB] FAIL trap_value1 got=%h exp=%h", value1, 32'h0000_1880); end
        checks++; if (irq1 !== 1'b0) begin errors++; $display("[TB] FAIL trap_irq1 got=%b exp=0", irq1); end
        stepEvent(1'b0, 1'b1);
        checks++; if (value1 !== 32'h0000_0088) begin errors++; $display("[TB] FAIL mret_value1 got=%h exp=%h", value1, 32'h0000_0088); end
        checks++; if (priv1 !== 2'b11) begin errors++; $display("[TB] FAIL mret_priv1 got=%b exp=11", priv1); end
        checks++; if (value0 !== 32'h0000_1888) begin errors++; $display("[TB] FAIL mret_value0 got=%h exp=%h", value0, 32'h0000_1888); end
    endtask

    task automatic test_umode();
        doReset();
        stepAccess(12'h300, 2'b01, 64'h0002_0000);
        checks++; if (value1 !== 32'h0002_0000) begin errors++; $display("[TB] FAIL umode_wr_value1 got=%h exp=%h", value1, 32'h0002_0000); end
        checks++; if (value0 !== 32'h0000_1800) begin errors++; $display("[TB] FAIL umode_wr_value0 got=%h exp=%h", value0, 32'h0000_1800); end
        stepEvent(1'b0, 1'b1);
        checks++; if (priv1 !== 2'b00) begin errors++; $display("[TB] FAIL umode_priv1 got=%b exp=00", priv1); end
        checks++; if (irq1 !== 1'b1) begin errors++; $display("[TB] FAIL umode_irq1 got=%b exp=1", irq1); end
        checks++; if (value1 !== 32'h0000_0080) begin errors++; $display("[TB] FAIL umode_mret_value1 got=%h exp=%h", value1, 32'h0000_0080); end
        checks++; if (priv0 !== 2'b11) begin errors++; $display("[TB] FAIL umode_priv0 got=%b exp=11", priv0); end
        stepAccess(12'h300, 2'b01, 64'h0000_0888);
        checks++; if (value1 !== 32'h0000_0088) begin errors++; $display("[TB] FAIL warl_value1 got=%h exp=%h", value1, 32'h0000_0088); end
        stepEvent(1'b1, 1'b0);
        checks++; if (value1 !== 32'h0000_0080) begin errors++; $display("[TB] FAIL utrap_value1 got=%h exp=%h", value1, 32'h0000_0080); end
        checks++; if (priv1 !== 2'b11) begin errors++; $display("[TB] FAIL utrap_priv1 got=%b exp=11", priv1); end
    endtask

    task automatic test_priority();
        doReset();
        stepAccess(12'h300, 2'b10, 64'h8);
        en = 1'b1; addr = 12'h300; op = 2'b01; wdata = 64'h8;
        stepEvent(1'b1, 1'b1);
        checks++; if (value1 !== 32'h0000_1880) begin errors++; $display("[TB] FAIL prio_trap_value1 got=%h exp=%h", value1, 32'h0000_1880); end
        checks++; if (ack1 !== 1'b1) begin errors++; $display("[TB] FAIL prio_trap_ack1 got=%b exp=1", ack1); end
        checks++; if (rdata1 !== 32'h0000_1808) begin errors++; $display("[TB] FAIL prio_trap_rdata1 got=%h exp=%h", rdata1, 32'h0000_1808); end
        en = 1'b1; addr = 12'h300; op = 2'b01; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        stepEvent(1'b0, 1'b1);
        checks++; if (value1 !== 32'h0000_0088) begin errors++; $display("[TB] FAIL prio_mret_value1 got=%h exp=%h", value1, 32'h0000_0088); end
        checks++; if (rdata1 !== 32'h0000_1880) begin errors++; $display("[TB] FAIL prio_mret_rdata1 got=%h exp=%h", rdata1, 32'h0000_1880); end
    endtask

    task automatic test_nomatch();
        stepAccess(12'h301, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (ack1 !== 1'b0) begin errors++; $display("[TB] FAIL nomatch_ack1 got=%b exp=0", ack1); end
        checks++; if (value1 !== 32'h0000_0088) begin errors++; $display("[TB] FAIL nomatch_value1 got=%h exp=%h", value1, 32'h0000_0088); end
        stepAccess(12'h300, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (rdata1 !== 32'h0000_0088) begin errors++; $display("[TB] FAIL read_rdata1 got=%h exp=%h", rdata1, 32'h0000_0088); end
        checks++; if (value1 !== 32'h0000_0088) begin errors++; $display("[TB] FAIL read_value1 got=%h exp=%h", value1, 32'h0000_0088); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  opList   [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] dataList [3] = '{32'h8, 32'h80, 32'h8};
        logic [31:0] rdExp    [3] = '{32'h0000_1800, 32'h0000_0008, 32'h0000_0088};
        logic [31:0] valExp   [3] = '{32'h0000_0008, 32'h0000_0088, 32'h0000_0080};
        doReset();
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; addr = 12'h300; op = opList[i]; wdata = {32'h0, dataList[i]};
            @(posedge clock);
            #1;
            checks++; if (ack1 !== 1'b1 || rdata1 !== rdExp[i]) begin errors++; $display("[TB] FAIL b2b_rdata%0d got ack=%b data=%h exp ack=1 data=%h", i, ack1, rdata1, rdExp[i]); end
            checks++; if (value1 !== valExp[i]) begin errors++; $display("[TB] FAIL b2b_value%0d got=%h exp=%h", i, value1, valExp[i]); end
        end
        driveIdle();
        @(posedge clock);
        #1;
        checks++; if (ack1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end_ack1 got=%b exp=0", ack1); end
    endtask

    task automatic test_reset_midaccess();
        doReset();
        stepAccess(12'h300, 2'b01, 64'h88);
        checks++; if (ack1 !== 1'b1 || value1 !== 32'h0000_0088) begin errors++; $display("[TB] FAIL mid_pre ack=%b value=%h exp ack=1 value=%h", ack1, value1, 32'h0000_0088); end
        resetN = 1'b0;
        #1;
        checks++; if (ack1 !== 1'b0) begin errors++; $display("[TB] FAIL mid_ack1 got=%b exp=0", ack1); end
        checks++; if (value1 !== 32'h0000_1800) begin errors++; $display("[TB] FAIL mid_value1 got=%h exp=%h", value1, 32'h0000_1800); end
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("[TB] FAIL mid_rdata1 got=%h exp=0", rdata1); end
        en = 1'b1; addr = 12'h300; op = 2'b01; wdata = 64'h8;
        @(posedge clock);
        #1;
        resetN = 1'b1;
        driveIdle();
        @(posedge clock);
        #1;
        checks++; if (ack1 !== 1'b0) begin errors++; $display("[TB] FAIL release_ack1 got=%b exp=0", ack1); end
        checks++; if (value1 !== 32'h0000_1800) begin errors++; $display("[TB] FAIL release_value1 got=%h exp=%h", value1, 32'h0000_1800); end
    endtask

    initial begin
        resetN = 1'b0;
        driveIdle();
        test_reset();
        test_write();
        test_trap_mret();
        test_umode();
        test_priority();
        test_nomatch();
        test_back_to_back();
        test_reset_midaccess();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
